gpio_bank_regs: RTL
===================

Name: gpio_bank_regs

Overview:
- Parametrised successor to the fixed 2/4-port GPIO register decoder: a register bank for NumGPIO ports of GPIOWidth pins each, packed linearly into RegWidth-bit words.
- Provides output data, DDR and open-drain registers, a synchronised input readback, and new per-pin edge capture with a W1C status register, an interrupt mask and a level irq output.
- Sits between the HPS/bus bridge and the pad-level bidir buffers; reads not claimed by this block pass the hm2 read data through.

Parameters:
- AddrWidth, 16, byte address width (bus carries [AddrWidth-1:2])
- BusWidth, 32, bus data width
- GPIOWidth, 36, pins per port
- NumGPIO, 2, number of ports (1..8)
- RegWidth, 24, used bits per register word (<= BusWidth)
- NumRegs, ceil(NumGPIO*GPIOWidth/RegWidth), words per register group (<= 64)
- DebounceDiv, 256, reg_clk cycles per debounce sample tick (optional feature only)

Ports:
- reg_clk  in  1  sole clock
- reset_reg_N  in  1  asynchronous active-low reset
- chip_sel  in  1  qualifies read_reg/write_reg
- write_reg  in  1  write strobe, one cycle
- read_reg  in  1  read strobe, one cycle
- busaddress  in  AddrWidth-2  word address [AddrWidth-1:2]
- busdata_in  in  BusWidth  write data
- busdata_fromhm2  in  BusWidth  pass-through read data
- busdata_out  out  BusWidth  read data
- read_valid  out  1  busdata_out holds this block's read result
- pin_in  in  NumGPIO*GPIOWidth  raw pad inputs, pin p = bit p
- pin_out  out  NumGPIO*GPIOWidth  pad output value
- pin_oe  out  NumGPIO*GPIOWidth  pad output enable
- irq  out  1  OR of (edge_status & irq_mask)

Behaviour:
- Single clock: reg_clk. Reset: asynchronous, active-low (reset_reg_N); all flops clear on assertion and release synchronously to reg_clk.
- Pin mapping: pin p is bit (p mod RegWidth) of word (p / RegWidth). Bits beyond the last pin, and bits [BusWidth-1:RegWidth], read 0; writes to them are ignored.
- Address map (byte offset, word n = 0..NumRegs-1):
  - 0x1000+4n  IO data (R/W)
  - 0x1100+4n  DDR (R/W)
  - 0x1200+4n  pin readback (RO, synchronised input)
  - 0x1300+4n  OD (R/W)
  - 0x1400+4n  edge status (R, W1C)
  - 0x1500+4n  irq mask (R/W)
  - 0x1600+4n  edge select (R/W): 0 = rising, 1 = falling
- Accesses with n >= NumRegs: reads return 0 with read_valid=1; writes are dropped.
- Bus stage: chip_sel, strobes, address and data are registered at edge E0.
- Write: a strobe sampled at E0 updates the register at E1. Writes to RO words are ignored.
- Read: a strobe sampled at E0 gives busdata_out valid and read_valid=1 from E2 for one cycle.
- Without a claimed read, busdata_out = busdata_fromhm2 registered by one cycle and read_valid=0.
- read_reg and write_reg asserted together: the write is performed and the read is ignored.
- Pad drive:
  - OD=1: pin_oe = ~io, pin_out = 0.
  - OD=0: pin_oe = DDR, pin_out = io.
  - Outputs are registered.
- Input sync: 2-flop synchroniser per pin, so readback latency is 2 cycles plus the read latency.
- Edge detect compares the synchronised sample with the previous sample.
  - Detection is suppressed for the first 3 cycles after reset release (priming counter), so no false edges come from reset values.
- Edge status: a selected edge sets the bit sticky. W1C clears it.
  - A set and a clear on the same bit in the same cycle: set wins.
- irq is registered, high while any masked status bit is set. It deasserts one cycle after the clearing write takes effect.
- Reset values: busdata_out 0, read_valid 0, pin_out 0, pin_oe 0, irq 0; all registers 0 (all pins inputs).

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - A free-running counter produces a tick every DebounceDiv cycles.
  - Each pin's synchronised value is accepted only after 3 consecutive equal tick samples.
  - Readback and edge detect use the accepted value.
  - Priming extends until 3 ticks have elapsed.
- Undefined: the counter and filter are absent; behaviour is as above with zero added latency.

Test Plan:
- Reset, then read 0x1000..0x1600 word 0 -> all 0, read_valid pulses 2 cycles after each read_reg, irq=0, pin_oe=0.
- Write DDR word0=0x000F0F, IO word0=0x000A05 -> pin_out[7:0]=0x05, pin_oe[11:0]=0xF0F one cycle after the write is registered; IO readback returns 0x000A05.
- Write OD word1=0x000001, IO word1=0 -> pin_oe[24]=1, pin_out[24]=0; then IO word1=1 -> pin_oe[24]=0.
- Mask word0=0x1, drive pin_in[0] 0->1 -> status word0 bit0=1, irq=1; write 0x1 to 0x1400 -> status 0, irq=0; repeat with the edge arriving in the same cycle as the W1C -> bit stays 1.
- Hold pin_in all-ones through reset release -> no status bits set; read of word n=NumRegs -> 0 with read_valid; write there -> no register changes.
- No claimed read, busdata_fromhm2=0xDEADBEEF -> busdata_out=0xDEADBEEF next cycle, read_valid=0; with GPIO_DEBOUNCE_EN, DebounceDiv=4, a 5-cycle glitch on pin_in[3] -> no status set, 16-cycle pulse -> status set.

Source files
------------

// File: rtl/gpio_bank_regs.sv
// GPIO register bank: data/DDR/open-drain pad control, synchronised readback and edge-capture irq.
// Define GPIO_DEBOUNCE_EN to add a tick-sampled 3-of-3 input debounce filter.
module gpio_bank_regs #(
  parameter int unsigned AddrWidth   = 16,
  parameter int unsigned BusWidth    = 32,
  parameter int unsigned GPIOWidth   = 36,
  parameter int unsigned NumGPIO     = 2,
  parameter int unsigned RegWidth    = 24,
  parameter int unsigned NumRegs     = (NumGPIO * GPIOWidth + RegWidth - 1) / RegWidth,
  parameter int unsigned DebounceDiv = 256
) (
  input  logic                         reg_clk,
  input  logic                         reset_reg_N,
  input  logic                         chip_sel,
  input  logic                         write_reg,
  input  logic                         read_reg,
  input  logic [AddrWidth-3:0]         busaddress,
  input  logic [BusWidth-1:0]          busdata_in,
  input  logic [BusWidth-1:0]          busdata_fromhm2,
  output logic [BusWidth-1:0]          busdata_out,
  output logic                         read_valid,
  input  logic [NumGPIO*GPIOWidth-1:0] pin_in,
  output logic [NumGPIO*GPIOWidth-1:0] pin_out,
  output logic [NumGPIO*GPIOWidth-1:0] pin_oe,
  output logic                         irq
);

  localparam int unsigned NumPins  = NumGPIO * GPIOWidth;
  localparam int unsigned WordBits = NumRegs * RegWidth;
  localparam int unsigned HiWidth  = AddrWidth - 8;

  typedef enum logic [2:0] {
    GrpIo   = 3'd0,
    GrpDdr  = 3'd1,
    GrpIn   = 3'd2,
    GrpOd   = 3'd3,
    GrpSts  = 3'd4,
    GrpMsk  = 3'd5,
    GrpEsel = 3'd6
  } grp_e;

  typedef logic [NumPins-1:0]  pins_t;
  typedef logic [RegWidth-1:0] word_t;

  // Pins are packed linearly into words; bits past the last pin are dropped.
  function automatic pins_t put_word(input pins_t cur, input logic [5:0] n, input word_t w);
    logic [WordBits-1:0] pad;
    pad = WordBits'(cur);
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (32'(n) == i) pad[i*RegWidth +: RegWidth] = w;
    end
    return pad[NumPins-1:0];
  endfunction

  function automatic word_t get_word(input pins_t cur, input logic [5:0] n);
    logic [WordBits-1:0] pad;
    word_t               w;
    pad = WordBits'(cur);
    w   = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (32'(n) == i) w = pad[i*RegWidth +: RegWidth];
    end
    return w;
  endfunction

  // Bus input stage
  logic                 req_wr_d, req_wr_q, req_rd_d, req_rd_q;
  logic [AddrWidth-3:0] req_addr_d, req_addr_q;
  word_t                req_data_d, req_data_q;
  logic                 unused_busdata;

  always_comb begin
    req_wr_d   = chip_sel & write_reg;
    req_rd_d   = chip_sel & read_reg & ~write_reg;
    req_addr_d = busaddress;
    req_data_d = busdata_in[RegWidth-1:0];
  end
  assign unused_busdata = ^(busdata_in >> RegWidth);

  // Word address decode: groups sit at word 0x400 + 0x40*g, word index in the low 6 bits.
  logic [HiWidth-1:0] hi;
  logic [5:0]         word_n;
  logic               in_bank, word_ok, wr_en, rd_en;
  grp_e               grp;

  always_comb begin
    hi      = req_addr_q[AddrWidth-3:6];
    word_n  = req_addr_q[5:0];
    in_bank = (hi >= HiWidth'(16)) && (hi <= HiWidth'(22));
    word_ok = 32'(word_n) < NumRegs;
    grp     = grp_e'(hi[2:0]);
    wr_en   = req_wr_q & in_bank & word_ok;
    rd_en   = req_rd_q & in_bank;
  end

  // Input path
  pins_t      sync1_q, sync2_q, prev_q, in_val;
  logic [1:0] prime_d, prime_q;
  logic       det_en;

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = (DebounceDiv > 1) ? $clog2(DebounceDiv) : 1;

  logic [CntW-1:0] div_d, div_q;
  logic            tick;
  pins_t           hist0_d, hist0_q, hist1_d, hist1_q, filt_d, filt_q, stable;
  logic            det_en_d, det_en_q;

  always_comb begin
    tick    = div_q == CntW'(DebounceDiv - 1);
    div_d   = tick ? '0 : div_q + 1'b1;
    hist0_d = hist0_q;
    hist1_d = hist1_q;
    filt_d  = filt_q;
    prime_d = prime_q;
    stable  = '0;
    if (tick) begin
      hist0_d = sync2_q;
      hist1_d = hist0_q;
      stable  = ~(sync2_q ^ hist0_q) & ~(hist0_q ^ hist1_q);
      filt_d  = (stable & sync2_q) | (~stable & filt_q);
      if (prime_q != 2'd3) prime_d = prime_q + 2'd1;
    end
    // Extra cycle lets prev_q catch up with the first accepted value.
    det_en_d = prime_q == 2'd3;
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      div_q    <= '0;
      hist0_q  <= '0;
      hist1_q  <= '0;
      filt_q   <= '0;
      det_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      hist0_q  <= hist0_d;
      hist1_q  <= hist1_d;
      filt_q   <= filt_d;
      det_en_q <= det_en_d;
    end
  end

  assign det_en = det_en_q;
  assign in_val = filt_q;
`else
  logic [31:0] unused_debounce_div;
  assign unused_debounce_div = 32'(DebounceDiv);

  always_comb begin
    prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
  end

  assign det_en = prime_q == 2'd3;
  assign in_val = sync2_q;
`endif

  // Register file, edge capture and pad drive
  pins_t io_d, io_q, ddr_d, ddr_q, od_d, od_q, mask_d, mask_q, esel_d, esel_q;
  pins_t status_d, status_q, clr, hit, pin_out_d, pin_out_q, pin_oe_d, pin_oe_q;
  logic  irq_d, irq_q;

  always_comb begin
    io_d   = io_q;
    ddr_d  = ddr_q;
    od_d   = od_q;
    mask_d = mask_q;
    esel_d = esel_q;
    clr    = '0;
    if (wr_en) begin
      unique case (grp)
        GrpIo:   io_d   = put_word(io_q, word_n, req_data_q);
        GrpDdr:  ddr_d  = put_word(ddr_q, word_n, req_data_q);
        GrpOd:   od_d   = put_word(od_q, word_n, req_data_q);
        GrpSts:  clr    = put_word('0, word_n, req_data_q);
        GrpMsk:  mask_d = put_word(mask_q, word_n, req_data_q);
        GrpEsel: esel_d = put_word(esel_q, word_n, req_data_q);
        default: ;
      endcase
    end
    hit = (in_val & ~prev_q & ~esel_q) | (~in_val & prev_q & esel_q);
    if (!det_en) hit = '0;
    // OR-ing hit after the clear makes a same-cycle set win over W1C.
    status_d  = (status_q & ~clr) | hit;
    pin_out_d = io_q & ~od_q;
    pin_oe_d  = (od_q & ~io_q) | (~od_q & ddr_q);
    irq_d     = |(status_q & mask_q);
  end

  // Read path
  word_t               rd_word;
  logic                rd_pend_d, rd_pend_q, read_valid_d, read_valid_q;
  logic [BusWidth-1:0] rd_data_d, rd_data_q, busdata_out_d, busdata_out_q;

  always_comb begin
    rd_word = '0;
    if (in_bank && word_ok) begin
      unique case (grp)
        GrpIo:   rd_word = get_word(io_q, word_n);
        GrpDdr:  rd_word = get_word(ddr_q, word_n);
        GrpIn:   rd_word = get_word(in_val, word_n);
        GrpOd:   rd_word = get_word(od_q, word_n);
        GrpSts:  rd_word = get_word(status_q, word_n);
        GrpMsk:  rd_word = get_word(mask_q, word_n);
        GrpEsel: rd_word = get_word(esel_q, word_n);
        default: ;
      endcase
    end
    rd_pend_d     = rd_en;
    rd_data_d     = BusWidth'(rd_word);
    busdata_out_d = rd_pend_q ? rd_data_q : busdata_fromhm2;
    read_valid_d  = rd_pend_q;
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      req_wr_q      <= 1'b0;
      req_rd_q      <= 1'b0;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      prime_q       <= '0;
      io_q          <= '0;
      ddr_q         <= '0;
      od_q          <= '0;
      mask_q        <= '0;
      esel_q        <= '0;
      status_q      <= '0;
      pin_out_q     <= '0;
      pin_oe_q      <= '0;
      irq_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_data_q     <= '0;
      busdata_out_q <= '0;
      read_valid_q  <= 1'b0;
    end else begin
      req_wr_q      <= req_wr_d;
      req_rd_q      <= req_rd_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      sync1_q       <= pin_in;
      sync2_q       <= sync1_q;
      prev_q        <= in_val;
      prime_q       <= prime_d;
      io_q          <= io_d;
      ddr_q         <= ddr_d;
      od_q          <= od_d;
      mask_q        <= mask_d;
      esel_q        <= esel_d;
      status_q      <= status_d;
      pin_out_q     <= pin_out_d;
      pin_oe_q      <= pin_oe_d;
      irq_q         <= irq_d;
      rd_pend_q     <= rd_pend_d;
      rd_data_q     <= rd_data_d;
      busdata_out_q <= busdata_out_d;
      read_valid_q  <= read_valid_d;
    end
  end

  assign busdata_out = busdata_out_q;
  assign read_valid  = read_valid_q;
  assign pin_out     = pin_out_q;
  assign pin_oe      = pin_oe_q;
  assign irq         = irq_q;

endmodule
